// File: rtl/kme_ib_framer_pkg.sv
// ============================================================================
// Module      : kme_ib_framer_pkg
// Description : Shared tuser codes, GUID flag position and framer state
//               encoding for the KME inbound TLV framer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef AXI_S_TID_WIDTH
`define AXI_S_TID_WIDTH 4
`endif

package kme_ib_framer_pkg;

    localparam logic [7:0] TUSER_SOT = 8'h01;
    localparam logic [7:0] TUSER_EOT = 8'h02;
    localparam logic [7:0] TUSER_MID = 8'h03;

    // Bit of mega word #2 that announces a trailing GUID TLV
    localparam int MEGA_GUID_BIT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TLV  = 2'd1,
        MEGA = 2'd2,
        GUID = 2'd3
    } framer_state_t;

endpackage

`default_nettype wire

// File: rtl/kme_axis_skid.sv
// ============================================================================
// Module      : kme_axis_skid
// Description : Two-entry registered skid buffer. The output register drives
//               the downstream port; the skid register catches the one word
//               that arrives while the output is stalled.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module kme_axis_skid #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             r_main_valid;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             w_push;

    // Upstream is only refused when both entries are occupied
    assign in_ready  = !r_skid_valid;
    assign w_push    = in_valid && !r_skid_valid;
    assign out_valid = r_main_valid;
    assign out_data  = r_main;

    // Output register refills from skid first to preserve order
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main       <= '0;
            r_skid       <= '0;
        end else if (!r_main_valid || out_ready) begin
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_main_valid <= w_push;
                if (w_push) begin
                    r_main <= in_data;
                end
            end
        end else if (w_push) begin
            r_skid       <= in_data;
            r_skid_valid <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/kme_ib_tlv_framer.sv
// ============================================================================
// Module      : kme_ib_tlv_framer
// Description : Classifies inbound KME TLV words, generates frame tlast
//               (mega TLV without GUID, or GUID TLV, ends a frame), flags
//               framing violations and forwards words through a skid stage.
//               Optional statistics counters: KME_IB_FRAMER_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module kme_ib_tlv_framer #(
    parameter int TID_W         = `AXI_S_TID_WIDTH,
    parameter int DATA_W        = 64,
    parameter int STRB_W        = 8,
    parameter int USER_W        = 8,
    parameter int MEGA_TYPE_MIN = 21,
    parameter int GUID_TYPE     = 10,
    parameter int CNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic [TID_W-1:0]  s_tid,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic [STRB_W-1:0] s_tstrb,
    input  logic [USER_W-1:0] s_tuser,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [TID_W-1:0]  m_tid,
    output logic [DATA_W-1:0] m_tdata,
    output logic [STRB_W-1:0] m_tstrb,
    output logic [USER_W-1:0] m_tuser,
    output logic              m_tlast,
    output logic              proto_err,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    import kme_ib_framer_pkg::*;

    localparam int         c_payload_w = TID_W + DATA_W + STRB_W + USER_W + 1;
    localparam logic [7:0] c_mega_min  = 8'(MEGA_TYPE_MIN);
    localparam logic [7:0] c_guid_type = 8'(GUID_TYPE);

    framer_state_t r_state, w_state_nxt;
    logic          r_have_guid, w_have_guid_nxt;
    logic [1:0]    r_mega_wc, w_mega_wc_nxt;
    logic          r_proto_err, w_err;
    logic          r_live;
    logic          w_skid_ready;
    logic          w_acc;
    logic          w_tlast;
    logic          w_is_sot, w_is_eot, w_is_mid;
    logic          w_guid_now;
    logic [7:0]    w_type;

    assign s_tready   = r_live && w_skid_ready;
    assign w_acc      = s_tvalid && s_tready;
    assign w_type     = s_tdata[7:0];
    assign w_is_sot   = (s_tuser == USER_W'(TUSER_SOT));
    assign w_is_eot   = (s_tuser == USER_W'(TUSER_EOT));
    assign w_is_mid   = (s_tuser == USER_W'(TUSER_MID));
    // GUID flag as seen by this word, including its own update when it is word #2
    assign w_guid_now = (r_mega_wc == 2'd1) ? s_tdata[MEGA_GUID_BIT] : r_have_guid;
    assign proto_err  = r_proto_err;

    // Holds s_tready low until the first clock after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_live <= 1'b0;
        else        r_live <= 1'b1;
    end

    // Framer state, mega word count, GUID flag and registered error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_have_guid <= 1'b0;
            r_mega_wc   <= 2'd0;
            r_proto_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_have_guid <= w_have_guid_nxt;
            r_mega_wc   <= w_mega_wc_nxt;
            r_proto_err <= w_err;
        end
    end

    // Next state, tlast and violation decode for each accepted word
    always_comb begin
        w_state_nxt     = r_state;
        w_have_guid_nxt = r_have_guid;
        w_mega_wc_nxt   = r_mega_wc;
        w_tlast         = 1'b0;
        w_err           = 1'b0;
        if (w_acc) begin
            if (w_is_sot) begin
                // A SoT always restarts classification, abandoning any open TLV
                w_err = (r_state != IDLE);
                if (w_type >= c_mega_min) begin
                    w_state_nxt     = MEGA;
                    w_have_guid_nxt = 1'b0;
                    w_mega_wc_nxt   = 2'd1;
                end else if (w_type == c_guid_type) begin
                    w_state_nxt = GUID;
                end else begin
                    w_state_nxt = TLV;
                end
            end else if (r_state == IDLE) begin
                w_err = 1'b1;
            end else if (w_is_eot) begin
                w_state_nxt = IDLE;
                case (r_state)
                    MEGA:    w_tlast = !w_guid_now;
                    GUID:    w_tlast = 1'b1;
                    default: w_tlast = 1'b0;
                endcase
            end else if (r_state == MEGA) begin
                w_have_guid_nxt = w_guid_now;
                if (r_mega_wc != 2'd3) begin
                    w_mega_wc_nxt = r_mega_wc + 2'd1;
                end
            end
            // Unknown tuser codes travel as middle words but are still flagged
            if (!(w_is_sot || w_is_eot || w_is_mid)) begin
                w_err = 1'b1;
            end
        end
    end

    kme_axis_skid #(
        .WIDTH (c_payload_w)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s_tvalid && r_live),
        .in_ready  (w_skid_ready),
        .in_data   ({s_tid, s_tdata, s_tstrb, s_tuser, w_tlast}),
        .out_valid (m_tvalid),
        .out_ready (m_tready),
        .out_data  ({m_tid, m_tdata, m_tstrb, m_tuser, m_tlast})
    );

`ifdef KME_IB_FRAMER_STATS_EN
    logic [CNT_W-1:0] r_frame_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    // Free-running wrap-around counters of closed frames and violations
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            if (m_tvalid && m_tready && m_tlast) r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            if (r_proto_err)                     r_err_cnt   <= r_err_cnt + CNT_W'(1);
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign err_cnt   = r_err_cnt;
`else
    assign frame_cnt = '0;
    assign err_cnt   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_kme_ib_tlv_framer.sv
// ============================================================================
// Module      : tb_kme_ib_tlv_framer
// Description : Self-checking bench for kme_ib_tlv_framer with a TLV-level
//               reference model. Honours KME_IB_FRAMER_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_kme_ib_tlv_framer;

    localparam int TID_W = 4;

    typedef struct packed {
        logic [TID_W-1:0] tid;
        logic [63:0]      data;
        logic [7:0]       strb;
        logic [7:0]       user;
        logic             last;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             s_tvalid, s_tready;
    logic [TID_W-1:0] s_tid, m_tid;
    logic [63:0]      s_tdata, m_tdata;
    logic [7:0]       s_tstrb, m_tstrb, s_tuser, m_tuser;
    logic             m_tvalid, m_tready, m_tlast, proto_err;
    logic [15:0]      frame_cnt, err_cnt;

    int    n_assert = 0;
    int    n_fail   = 0;
    int    obs_err  = 0;
    int    exp_err  = 0;
`ifdef KME_IB_FRAMER_STATS_EN
    int    exp_frames = 0;
`endif
    bit    rnd_ready = 1'b0;
    beat_t exp_q[$];
    beat_t got_q[$];
    beat_t mon_b;

    // Reference model state: one open TLV at a time
    bit md_open = 1'b0;
    int md_kind = 0;   // 0 plain, 1 mega, 2 guid
    int md_idx  = 0;   // words seen in the open TLV
    bit md_guid = 1'b0;

    kme_ib_tlv_framer #(.TID_W(TID_W)) dut (
        .clk (clk), .rst_n (rst_n),
        .s_tvalid (s_tvalid), .s_tready (s_tready), .s_tid (s_tid),
        .s_tdata (s_tdata), .s_tstrb (s_tstrb), .s_tuser (s_tuser),
        .m_tvalid (m_tvalid), .m_tready (m_tready), .m_tid (m_tid),
        .m_tdata (m_tdata), .m_tstrb (m_tstrb), .m_tuser (m_tuser),
        .m_tlast (m_tlast), .proto_err (proto_err),
        .frame_cnt (frame_cnt), .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Output monitor: records every transfer and every proto_err cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_tvalid && m_tready) begin
                mon_b.tid  = m_tid;  mon_b.data = m_tdata; mon_b.strb = m_tstrb;
                mon_b.user = m_tuser; mon_b.last = m_tlast;
                got_q.push_back(mon_b);
            end
            if (proto_err) obs_err++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Framing rules applied TLV by TLV to each accepted word
    task automatic model_accept(input logic [7:0] user, input logic [63:0] data,
                                input logic [TID_W-1:0] tid, input logic [7:0] strb);
        bit         err  = 1'b0;
        bit         last = 1'b0;
        logic [7:0] u    = user;
        beat_t      b;
        if (!(u inside {8'h01, 8'h02, 8'h03})) begin
            err = 1'b1;
            u   = 8'h03;
        end
        if (u == 8'h01) begin
            if (md_open) err = 1'b1;
            md_open = 1'b1;
            md_idx  = 1;
            if (data[7:0] >= 8'd21) begin
                md_kind = 1;
                md_guid = 1'b0;
            end else if (data[7:0] == 8'd10) begin
                md_kind = 2;
            end else begin
                md_kind = 0;
            end
        end else if (!md_open) begin
            err = 1'b1;
        end else begin
            md_idx++;
            if (md_kind == 1 && md_idx == 2) md_guid = data[4];
            if (u == 8'h02) begin
                md_open = 1'b0;
                last    = (md_kind == 1) ? !md_guid : (md_kind == 2);
            end
        end
        b.tid = tid; b.data = data; b.strb = strb; b.user = user; b.last = last;
        exp_q.push_back(b);
        if (err) exp_err++;
`ifdef KME_IB_FRAMER_STATS_EN
        if (last) exp_frames++;
`endif
    endtask

    // Present one word until accepted; returns at posedge+1 after the transfer
    task automatic send_word(input logic [7:0] user, input logic [63:0] data);
        logic [TID_W-1:0] tid  = TID_W'($urandom);
        logic [7:0]       strb = 8'($urandom);
        int               n    = 0;
        bit               done = 1'b0;
        s_tvalid = 1'b1; s_tuser = user; s_tdata = data; s_tid = tid; s_tstrb = strb;
        while (!done) begin
            if (rnd_ready) m_tready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (s_tready) begin
                model_accept(user, data, tid, strb);
                done = 1'b1;
            end else if (n > 200) begin
                chk("send_timeout", 64'd0, 64'd1);
                done = 1'b1;
            end
            n++;
            @(posedge clk); #1;
        end
        s_tvalid = 1'b0;
    endtask

    // Present one word for exactly one cycle
    task automatic try_cycle(input logic [7:0] user, input logic [63:0] data, output bit acc);
        logic [TID_W-1:0] tid  = TID_W'($urandom);
        logic [7:0]       strb = 8'($urandom);
        s_tvalid = 1'b1; s_tuser = user; s_tdata = data; s_tid = tid; s_tstrb = strb;
        @(negedge clk);
        acc = s_tready;
        if (acc) model_accept(user, data, tid, strb);
        @(posedge clk); #1;
        s_tvalid = 1'b0;
    endtask

    task automatic drain_compare();
        int n = 0;
        int m;
        s_tvalid = 1'b0; rnd_ready = 1'b0; m_tready = 1'b1;
        while (got_q.size() < exp_q.size() && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) begin @(posedge clk); #1; end
        chk("beat_count", 64'(got_q.size()), 64'(exp_q.size()));
        m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            chk("beat_data", got_q[i].data, exp_q[i].data);
            chk("beat_side", 64'({got_q[i].tid, got_q[i].strb, got_q[i].user, got_q[i].last}),
                             64'({exp_q[i].tid, exp_q[i].strb, exp_q[i].user, exp_q[i].last}));
        end
        chk("perr_count", 64'(obs_err), 64'(exp_err));
    endtask

    task automatic clear_q();
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [63:0] words[6];
        logic [63:0] held;
        bit          acc;
        bit          stable;
        int          idx;
        int          n_acc;
        int          r;
        logic [7:0]  u;
        logic [63:0] d;

        rst_n = 1'b0; s_tvalid = 1'b0; m_tready = 1'b0;
        s_tid = '0; s_tdata = '0; s_tstrb = '0; s_tuser = '0;

        // ---- reset values ----
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_tready", 64'(s_tready), 64'd0);
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_m_tdata", m_tdata, 64'd0);
        chk("rst_m_tlast", 64'(m_tlast), 64'd0);
        chk("rst_proto_err", 64'(proto_err), 64'd0);
        chk("rst_counters", 64'({frame_cnt, err_cnt}), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_s_tready", 64'(s_tready), 64'd1);

        // ---- plain TLV with latency check ----
        m_tready = 1'b1;
        send_word(8'h01, 64'h1111_2222_3333_4401);
        chk("latency_valid", 64'(m_tvalid), 64'd1);
        chk("latency_data", m_tdata, 64'h1111_2222_3333_4401);
        send_word(8'h03, 64'hA5A5_0000_0000_0002);
        send_word(8'h03, 64'hA5A5_0000_0000_0003);
        send_word(8'h02, 64'hA5A5_0000_0000_0004);
        drain_compare();
        chk("plain_no_last", 64'({got_q[0].last, got_q[1].last, got_q[2].last, got_q[3].last}), 64'd0);
        clear_q();

        // ---- mega TLV without GUID ----
        send_word(8'h01, 64'h0000_0000_0000_0015);
        send_word(8'h03, 64'h0);
        send_word(8'h03, 64'hFFFF_FFFF_FFFF_FFFF);
        send_word(8'h02, 64'h1234_5678_9ABC_DEF0);
        drain_compare();
        chk("mega_lasts", 64'({got_q[0].last, got_q[1].last, got_q[2].last, got_q[3].last}), 64'b0001);
`ifdef KME_IB_FRAMER_STATS_EN
        chk("frame_cnt_1", 64'(frame_cnt), 64'd1);
`else
        chk("frame_cnt_off", 64'(frame_cnt), 64'd0);
`endif
        clear_q();

        // ---- mega TLV with GUID flag followed by GUID TLV ----
        send_word(8'h01, 64'h0000_0000_0000_0016);
        send_word(8'h03, 64'h0000_0000_0000_0010);
        send_word(8'h03, 64'h0000_0000_0000_0000);
        send_word(8'h02, 64'h0000_0000_0000_0000);
        send_word(8'h01, 64'h0000_0000_0000_000A);
        send_word(8'h02, 64'hCAFE_F00D_0000_0000);
        drain_compare();
        chk("guid_lasts", 64'({got_q[3].last, got_q[5].last}), 64'b01);
`ifdef KME_IB_FRAMER_STATS_EN
        chk("frame_cnt_2", 64'(frame_cnt), 64'd2);
`endif
        clear_q();

        // ---- backpressure: 5 stalled cycles mid-stream ----
        words[0] = 64'h0B0B_0000_0000_0001;
        for (int i = 1; i < 5; i++) words[i] = {32'hB0B0_0000, 32'(i)};
        words[5] = 64'hB0B0_FFFF_0000_0005;
        send_word(8'h01, words[0]);
        held = m_tdata;
        m_tready = 1'b0;
        idx = 1; n_acc = 0; stable = 1'b1;
        for (int c = 0; c < 5; c++) begin
            try_cycle(8'h03, words[idx], acc);
            if (acc) begin idx++; n_acc++; end
            stable &= (m_tvalid === 1'b1) && (m_tdata === held);
        end
        chk("stall_accept_le2", 64'(n_acc <= 2), 64'd1);
        chk("stall_s_tready", 64'(s_tready), 64'd0);
        chk("stall_hold", 64'(stable), 64'd1);
        m_tready = 1'b1;
        while (idx < 5) begin send_word(8'h03, words[idx]); idx++; end
        send_word(8'h02, words[5]);
        drain_compare();
        clear_q();

        // ---- violations ----
        send_word(8'h02, 64'hDEAD_0000_0000_0000);
        chk("viol_eot_idle", 64'(proto_err), 64'd1);
        send_word(8'h01, 64'h0000_0000_0000_0001);
        chk("viol_sot_ok", 64'(proto_err), 64'd0);
        send_word(8'h01, 64'h0000_0000_0000_000A);
        chk("viol_sot_sot", 64'(proto_err), 64'd1);
        send_word(8'h02, 64'h0000_0000_0000_0000);
        chk("viol_eot_ok", 64'(proto_err), 64'd0);
        drain_compare();
        chk("viol_pulses", 64'(obs_err), 64'd2);
        chk("viol_fresh_guid", 64'({got_q[0].last, got_q[2].last, got_q[3].last}), 64'b001);
`ifdef KME_IB_FRAMER_STATS_EN
        chk("err_cnt_2", 64'(err_cnt), 64'd2);
`else
        chk("err_cnt_off", 64'(err_cnt), 64'd0);
`endif
        clear_q();

        // ---- randomized traffic with random backpressure ----
        rnd_ready = 1'b1;
        for (int k = 0; k < 200; k++) begin
            r = $urandom_range(0, 19);
            u = (r < 4) ? 8'h01 : (r < 15) ? 8'h03 : (r < 19) ? 8'h02 : (r[0] ? 8'h07 : 8'h00);
            d = {$urandom, $urandom};
            case ($urandom_range(0, 4))
                0: d[7:0] = 8'h01;
                1: d[7:0] = 8'h0A;
                2: d[7:0] = 8'h15;
                3: d[7:0] = 8'h30;
                default: ;
            endcase
            send_word(u, d);
            rnd_ready = 1'b1;
            if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
        end
        drain_compare();
`ifdef KME_IB_FRAMER_STATS_EN
        chk("rand_frame_cnt", 64'(frame_cnt), 64'(exp_frames));
        chk("rand_err_cnt", 64'(err_cnt), 64'(exp_err));
`endif
        clear_q();

        // ---- asynchronous reset during a mega TLV ----
        m_tready = 1'b0;
        send_word(8'h01, 64'h0000_0000_0000_0020);
        send_word(8'h03, 64'h5555_0000_0000_0010);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("arst_m_tdata", m_tdata, 64'd0);
        chk("arst_m_side", 64'({m_tid, m_tstrb, m_tuser, m_tlast}), 64'd0);
        chk("arst_s_tready", 64'(s_tready), 64'd0);
        clear_q();
        obs_err = 0; exp_err = 0;
`ifdef KME_IB_FRAMER_STATS_EN
        exp_frames = 0;
`endif
        md_open = 1'b0; md_kind = 0; md_idx = 0; md_guid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_release_ready", 64'(s_tready), 64'd1);
        chk("arst_counters", 64'({frame_cnt, err_cnt}), 64'd0);
        m_tready = 1'b1;
        send_word(8'h02, 64'h7777_0000_0000_0000);
        chk("arst_orphan_eot", 64'(proto_err), 64'd1);
        drain_compare();
`ifdef KME_IB_FRAMER_STATS_EN
        chk("arst_err_cnt", 64'(err_cnt), 64'd1);
`endif
        clear_q();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
